muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide execution unit for the unsigned 8-bit datapath. It sits directly downstream of the register file: it consumes the two register read outputs as operands and produces a result plus write-back controls for the register file's write port. It handles the operations too costly for the single-cycle ALU. The core stalls on `busy` until `done` pulses.

## Interface
- `WIDTH`, default 8: operand and result width; must match the register width.
- `DEPTH`, default 8: number of registers; the address width is `$clog2(DEPTH)`.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: request a new operation; accepted only in IDLE.
- `op` input, 2 bits: operation code.
  - 00: MUL, low half of the product.
  - 01: MULHU, high half of the product.
  - 10: DIVU, quotient.
  - 11: REMU, remainder.
- `operand_a` input, WIDTH bits: multiplicand or dividend (register read port 1).
- `operand_b` input, WIDTH bits: multiplier or divisor (register read port 2).
- `dest_addr` input, `$clog2(DEPTH)` bits: destination register of the result.
- `busy` output, 1 bit: high while not IDLE.
- `done` output, 1 bit: one-cycle completion pulse.
- `wb_en` output, 1 bit: register-file write enable; identical to `done`.
- `wb_addr` output, `$clog2(DEPTH)` bits: latched `dest_addr`.
- `wb_data` output, WIDTH bits: result; holds its value until the next completion.

## Operation
- States and transitions:
  - IDLE: `start` goes to RUN; or to DONE directly on a divide-by-zero or a compiled-out divide.
  - RUN: lasts exactly WIDTH cycles, tracked by a counter of `$clog2(WIDTH)+1` bits; then goes to DONE.
  - DONE: always returns to IDLE after one cycle.
- On acceptance, `op`, `operand_a`, `operand_b` and `dest_addr` are latched. Later input changes do not affect the running operation.
- MUL/MULHU use shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - MUL returns `product[WIDTH-1:0]`; MULHU returns `product[2*WIDTH-1:WIDTH]`.
- DIVU/REMU use restoring division, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
- Divide by zero (`operand_b == 0` at acceptance) skips RUN.
  - DIVU returns all-ones.
  - REMU returns `operand_a`.
- `start` while `busy` is ignored. It is neither queued nor does it disturb the operation.
- `wb_en`/`done` are high only in DONE. `wb_addr` and `wb_data` are valid in that cycle.
- Reset values: `busy`=0, `done`=0, `wb_en`=0, `wb_addr`=0, `wb_data`=0; state is IDLE; the counter and accumulators are 0.
- Reset asserted mid-operation aborts it immediately: no write-back occurs and the state is IDLE on release.

## Timing
- Start accepted at edge T (IDLE and `start`=1): `busy`=1 from T.
- Normal operation: `done`/`wb_en` are high for the single cycle after edge T+WIDTH+1; IDLE is re-entered at edge T+WIDTH+2.
  - With WIDTH=8: accepted at edge 0, result written at edge 10.
- Short path (divide-by-zero or compiled-out divide): DONE is the cycle after edge T+1; IDLE at edge T+2.
- Back-to-back throughput: the next start is accepted at the earliest at edge T+WIDTH+2 (normal) or T+2 (short path).
- `busy` is low in IDLE only, so `busy` is still high in the DONE cycle. The core's stall releases the cycle after `done`.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `MULDIV_DIV_EN` defined: the DIVU/REMU datapath is compiled in, as described above.
- Not defined: the divider logic and partial-remainder register are removed.
  - Ops 10/11 take the short path and return all-ones for both DIVU and REMU, with normal write-back.
  - MUL/MULHU are unaffected.

## Test plan
- Reset with `rst_n`=0, then release → all outputs 0. Then MUL with a=13, b=11 → `wb_data`=0x8F, `wb_en` high for exactly one cycle at edge 10, `wb_addr` equals the latched `dest_addr`.
- MUL and MULHU with a=200, b=200 → 0x40 and 0x9C respectively. Change `operand_a` during RUN → result unchanged.
- DIVU and REMU with a=200, b=7 → 28 (0x1C) and 4 respectively, each after 10 edges. With the macro undefined → 0xFF on both, `done` at edge 2.
- DIVU with a=0x5A, b=0 → 0xFF at edge 2. REMU with a=0x5A, b=0 → 0x5A at edge 2. Neither visits RUN.
- Pulse `start` at edges 3 and 9 during a running MUL → exactly one `done`, carrying the result of the first operation. A start at edge 10 (DONE) is also ignored; a start at edge 11 is accepted.
- Assert `rst_n`=0 at edge 5 of a MUL → `busy`, `done`, `wb_en` and `wb_data` drop to 0 asynchronously. After release, no `wb_en` pulse occurs.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand/request and write-back bundle between the core and muldiv_unit
// Parameters: WIDTH operand/result width, DEPTH register count (address width $clog2(DEPTH)).
// Signals: start/op/operand_a/operand_b/dest_addr driven by the core (master);
//          busy/done/wb_en/wb_addr/wb_data driven by the unit (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [AW-1:0]    dest_addr;
    logic             busy;
    logic             done;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    modport master (
        output start, op, operand_a, operand_b, dest_addr,
        input  busy, done, wb_en, wb_addr, wb_data
    );
    modport slave (
        input  start, op, operand_a, operand_b, dest_addr,
        output busy, done, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit feeding the register-file write port
// Ports: clk (rising edge), rst_n (async, active-low), bus (muldiv_unit_if.slave):
//        start/op/operand_a/operand_b/dest_addr in; busy/done/wb_en/wb_addr/wb_data out.
// op: 00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder).
// Build option: define MULDIV_DIV_EN to include the restoring divider; without it
// DIVU/REMU take the short path and return all-ones.
module muldiv_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SKIP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Low half starts as multiplier (shifted out LSB first) or dividend (shifted out
    // MSB first, quotient bits shifted in); high half accumulates the product.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH:0]     madd;
    logic [WIDTH-1:0]   mul_res, div_res, skip_res;

    assign madd    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_res = op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] rem_q, rem_d;
    logic [WIDTH:0] rem_sh;
    logic           ge;
    assign rem_sh   = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign ge       = rem_sh >= {1'b0, opnd_q};
    assign div_res  = op_q[0] ? rem_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Short path with the divider present is only divide-by-zero: REMU yields the dividend.
    assign skip_res = op_q[0] ? acc_q[WIDTH-1:0] : '1;
`else
    assign div_res  = '1;
    assign skip_res = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef MULDIV_DIV_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            S_IDLE: if (bus.start) begin
                op_d    = bus.op;
                addr_d  = bus.dest_addr;
                opnd_d  = bus.op[1] ? bus.operand_b : bus.operand_a;
                acc_d   = {{WIDTH{1'b0}}, bus.op[1] ? bus.operand_a : bus.operand_b};
                cnt_d   = '0;
`ifdef MULDIV_DIV_EN
                rem_d   = '0;
`endif
                state_d = (bus.op[1] && (!DIV_EN || bus.operand_b == '0)) ? S_SKIP : S_RUN;
            end
            // WIDTH iteration edges, then one edge to register the selected result.
            S_RUN: if (cnt_q == CW'(WIDTH)) begin
                state_d = S_DONE;
                data_d  = op_q[1] ? div_res : mul_res;
            end else begin
                cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    rem_d              = ge ? rem_sh - {1'b0, opnd_q} : rem_sh;
                    acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ge};
                end else
`endif
                acc_d = {madd, acc_q[WIDTH-1:1]};
            end
            S_SKIP: begin
                state_d = S_DONE;
                data_d  = skip_res;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef MULDIV_DIV_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef MULDIV_DIV_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign bus.busy    = state_q != S_IDLE;
    assign bus.done    = state_q == S_DONE;
    assign bus.wb_en   = state_q == S_DONE;
    assign bus.wb_addr = addr_q;
    assign bus.wb_data = data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (table vectors, random ops, corner sequences)
module tb_muldiv_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    muldiv_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] addr;
        logic [7:0] exp;
        bit         perturb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'(b);
        case (op)
            2'b00: return 8'(p % 256);
            2'b01: return 8'(p / 256);
            2'b10: return (!DIV_EN || b == 0) ? 8'hFF : a / b;
            default: return !DIV_EN ? 8'hFF : (b == 0 ? a : a % b);
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] addr, input logic [7:0] exp, input bit perturb,
                          input string name);
        int k;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.dest_addr = addr;
        @(posedge clk); #1;
        chk({name, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        if (perturb) begin
            bus.operand_a = ~a; bus.operand_b = b + 8'd1; bus.op = ~op; bus.dest_addr = ~addr;
        end
        lat = (op[1] && (!DIV_EN || b == 0)) ? 1 : WIDTH + 1;
        k = 0;
        while (!bus.done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, " done_edge"}, 32'(k), 32'(lat));
        chk({name, " wb_data"}, 32'(bus.wb_data), 32'(exp));
        chk({name, " wb_addr"}, 32'(bus.wb_addr), 32'(addr));
        chk({name, " wb_en"}, 32'(bus.wb_en), 32'd1);
        chk({name, " busy_in_done"}, 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        chk({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({name, " idle_after"}, 32'(bus.busy), 32'd0);
        chk({name, " wb_data_held"}, 32'(bus.wb_data), 32'(exp));
    endtask

    initial begin
        vec_t vecs[13];
        int   pulses;
        logic [1:0] rop;
        logic [7:0] ra, rb;
        bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0; bus.dest_addr = '0;

        vecs[0]  = '{2'b00, 8'd13,  8'd11,  3'd5, 8'h8F, 1'b0};
        vecs[1]  = '{2'b00, 8'd200, 8'd200, 3'd1, 8'h40, 1'b1};
        vecs[2]  = '{2'b01, 8'd200, 8'd200, 3'd2, 8'h9C, 1'b1};
        vecs[3]  = '{2'b10, 8'd200, 8'd7,   3'd3, DIV_EN ? 8'h1C : 8'hFF, 1'b0};
        vecs[4]  = '{2'b11, 8'd200, 8'd7,   3'd4, DIV_EN ? 8'h04 : 8'hFF, 1'b1};
        vecs[5]  = '{2'b10, 8'h5A,  8'h00,  3'd6, 8'hFF, 1'b0};
        vecs[6]  = '{2'b11, 8'h5A,  8'h00,  3'd7, DIV_EN ? 8'h5A : 8'hFF, 1'b0};
        vecs[7]  = '{2'b01, 8'hFF,  8'hFF,  3'd0, 8'hFE, 1'b0};
        vecs[8]  = '{2'b00, 8'hFF,  8'hFF,  3'd1, 8'h01, 1'b0};
        vecs[9]  = '{2'b10, 8'd7,   8'd200, 3'd2, DIV_EN ? 8'h00 : 8'hFF, 1'b0};
        vecs[10] = '{2'b11, 8'd7,   8'd200, 3'd3, DIV_EN ? 8'h07 : 8'hFF, 1'b0};
        vecs[11] = '{2'b10, 8'hFF,  8'h01,  3'd4, 8'hFF, 1'b0};
        vecs[12] = '{2'b00, 8'h00,  8'h77,  3'd5, 8'h00, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset wb_en", 32'(bus.wb_en), 32'd0);
        chk("reset wb_addr", 32'(bus.wb_addr), 32'd0);
        chk("reset wb_data", 32'(bus.wb_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].addr, vecs[i].exp, vecs[i].perturb,
                   $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            run_op(rop, ra, rb, 3'($urandom), model(rop, ra, rb), 1'($urandom), $sformatf("rnd%0d", i));
        end

        // Starts during RUN and during DONE are dropped; the first IDLE start is taken.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 8'd9; bus.operand_b = 8'd7; bus.dest_addr = 3'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            bus.start = (k == 3 || k == 9 || k == 10 || k == 11);
            bus.op = 2'b00; bus.operand_a = 8'd3; bus.operand_b = 8'd5; bus.dest_addr = 3'd6;
            @(posedge clk); #1;
            if (bus.done) begin
                pulses++;
                chk("ignore_start wb_data", 32'(bus.wb_data), 32'h3F);
                chk("ignore_start wb_addr", 32'(bus.wb_addr), 32'd2);
                chk("ignore_start done_edge", 32'(k), 32'd9);
            end
            if (k == 10) chk("ignore_start idle_at_10", 32'(bus.busy), 32'd0);
        end
        chk("ignore_start busy_at_11", 32'(bus.busy), 32'd1);
        chk("ignore_start pulses", 32'(pulses), 32'd1);
        bus.start = 1'b0;
        pulses = 0;
        while (!bus.done && pulses < 40) begin
            @(posedge clk); #1;
            pulses++;
        end
        chk("second_op done_edge", 32'(pulses), 32'd9);
        chk("second_op wb_data", 32'(bus.wb_data), 32'd15);
        chk("second_op wb_addr", 32'(bus.wb_addr), 32'd6);
        @(posedge clk); #1;

        // Reset in the middle of a MUL aborts it with no write-back.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 8'h11; bus.operand_b = 8'h0F; bus.dest_addr = 3'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("abort pre busy", 32'(bus.busy), 32'd1);
        chk("abort pre wb_data", 32'(bus.wb_data), 32'd15);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort wb_en", 32'(bus.wb_en), 32'd0);
        chk("abort wb_data", 32'(bus.wb_data), 32'd0);
        chk("abort wb_addr", 32'(bus.wb_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.wb_en || bus.busy) pulses++;
        end
        chk("abort no_writeback", 32'(pulses), 32'd0);

        run_op(2'b01, 8'hAB, 8'hCD, 3'd7, model(2'b01, 8'hAB, 8'hCD), 1'b0, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
